// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the param_alu slice.
//   - alu_state_t : handshake FSM states (IDLE, BUSY, DONE)
//   - md_kind_t   : operation selector for the iterative mul/div datapath
//   - OP_*        : 4-bit alu_control opcode values
//   - is_iter_op  : 1 for opcodes handled by the iterative datapath
//   - md_kind_of  : maps an iterative opcode onto md_kind_t
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } alu_state_t;

  typedef enum logic [1:0] {
    MD_MUL,
    MD_DIVU,
    MD_REMU
  } md_kind_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic md_kind_t md_kind_of(input logic [3:0] op);
    md_kind_t k;
    case (op)
      OP_MUL:  k = MD_MUL;
      OP_DIVU: k = MD_DIVU;
      default: k = MD_REMU;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative multiply / unsigned divide / unsigned remainder.
// One iteration per clock, exactly XLEN iterations per operation.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : 1-cycle request; a, b and kind are captured on this edge
//   kind       : MD_MUL (low XLEN bits of a*b), MD_DIVU (a/b), MD_REMU (a%b)
//   a, b       : operands
//   done       : 1-cycle pulse, high in the cycle after the last iteration
//   result     : valid while done is high and held until the next start
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  md_kind_t        kind,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic            busy;
  logic [CW-1:0]   cnt;
  md_kind_t        kind_q;

  // shift-add multiply state
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;

  // restoring divide state
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;

  logic [XLEN:0]   rem_sh;
  logic            fits;
  logic [XLEN-1:0] rem_sub;

  // Shifted partial remainder is XLEN+1 bits wide so a set MSB in rem is not
  // lost; the unsigned compare keeps divide-by-zero producing all-ones
  // quotient and remainder == dividend without a special case.
  always_comb begin
    rem_sh  = {rem, quo[XLEN-1]};
    fits    = (rem_sh >= {1'b0, dvs});
    rem_sub = rem_sh[XLEN-1:0] - dvs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      kind_q <= MD_MUL;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy   <= 1'b1;
        cnt    <= '0;
        kind_q <= kind;
        acc    <= '0;
        mcand  <= a;
        mplier <= b;
        rem    <= '0;
        quo    <= a;
        dvs    <= b;
      end else if (busy) begin
        if (kind_q == MD_MUL) begin
          acc    <= acc + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end else begin
          if (fits) begin
            rem <= rem_sub;
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= rem_sh[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
        end
        if (cnt == CW'(XLEN - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (kind_q)
      MD_MUL:  result = acc;
      MD_DIVU: result = quo;
      default: result = rem;
    endcase
  end

endmodule

// File: rtl/param_alu.sv
// param_alu: registered ALU with a valid/ready request and result handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : request handshake; in_ready is high only in IDLE
//   a, b, alu_control : operands and opcode, captured on acceptance
//   out_valid/out_ready : result handshake; out_valid is high only in DONE
//   ALU_Result, zero  : registered result and (ALU_Result == 0) flag
// Single-cycle ops produce out_valid one cycle after acceptance; MUL, DIVU
// and REMU go through alu_muldiv_iter and take XLEN+1 cycles.
module param_alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALU_Result,
  output logic            zero
);

  alu_state_t      state;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [3:0]      op_code;

  logic            accept;
  logic            iter_start;
  logic            iter_done;
  logic [XLEN-1:0] iter_result;
  logic [XLEN-1:0] single_result;
  logic [SHW-1:0]  shamt;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign iter_start = accept && is_iter_op(alu_control);

  alu_muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (iter_start),
    .kind  (md_kind_of(alu_control)),
    .a     (a),
    .b     (b),
    .done  (iter_done),
    .result(iter_result)
  );

  assign shamt = op_b[SHW-1:0];

  // Evaluated from the captured operands so later input changes cannot leak
  // into the result.
  always_comb begin
    single_result = '0;
    case (op_code)
      OP_AND:  single_result = op_a & op_b;
      OP_OR:   single_result = op_a | op_b;
      OP_ADD:  single_result = op_a + op_b;
      OP_SUB:  single_result = op_a - op_b;
      OP_XOR:  single_result = op_a ^ op_b;
      OP_SLL:  single_result = op_a << shamt;
      OP_SRL:  single_result = op_a >> shamt;
      OP_SRA:  single_result = $signed(op_a) >>> shamt;
      OP_SLT:  single_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: single_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: single_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      ALU_Result <= '0;
      zero       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a    <= a;
            op_b    <= b;
            op_code <= alu_control;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (!is_iter_op(op_code)) begin
            ALU_Result <= single_result;
            zero       <= (single_result == '0);
            state      <= DONE;
          end else if (iter_done) begin
            ALU_Result <= iter_result;
            zero       <= (iter_result == '0);
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
